// File: rtl/branch_pred_unit.sv
// Fetch-stage branch predictor: fully associative BTB with 2-bit counters, optional return-address stack (BPU_RAS_EN).
// Latency: prediction is combinational (0 cycles); updates, pushes and pops become visible the cycle after their edge.
// Backpressure: none; every lookup, update and push/pop strobe is accepted every cycle.
module branch_pred_unit #(
  parameter int ENTRIES   = 4,
  parameter int ADR_W     = 32,
  parameter int RAS_DEPTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [ADR_W-1:0] LOOKUP_ADR_SI,
  output logic             PRED_TAKEN_SP,
  output logic [ADR_W-1:0] PRED_ADR_SP,
  input  logic             UPD_VALID_SD,
  input  logic [ADR_W-1:0] UPD_ADR_SD,
  input  logic [ADR_W-1:0] UPD_TARGET_SD,
  input  logic             UPD_TAKEN_SD,
  input  logic             UPD_IS_RET_SD,
  input  logic             RAS_PUSH_SD,
  input  logic             RAS_POP_SD,
  input  logic [ADR_W-1:0] RAS_ADR_SD,
  output logic             RAS_EMPTY_SP
);
  localparam int IW = $clog2(ENTRIES);

  logic             r_vld [ENTRIES];
  logic [ADR_W-1:0] r_tag [ENTRIES];
  logic [ADR_W-1:0] r_tgt [ENTRIES];
  logic             r_ret [ENTRIES];
  logic [1:0]       r_ctr [ENTRIES];
  logic [IW-1:0]    r_ptr;

  logic             w_lk_hit;
  logic [IW-1:0]    w_lk_idx;
  logic             w_up_hit;
  logic [IW-1:0]    w_up_idx;
  logic             w_upd_ret;
  logic             w_ras_nz;
  logic [ADR_W-1:0] w_ras_top;

  // Associative match for lookup and update; descending scan so the lowest index wins.
  always_comb begin
    w_lk_hit = 1'b0;
    w_lk_idx = '0;
    w_up_hit = 1'b0;
    w_up_idx = '0;
    for (int i = ENTRIES - 1; i >= 0; i--) begin
      if (r_vld[i] && (r_tag[i] == LOOKUP_ADR_SI)) begin
        w_lk_hit = 1'b1;
        w_lk_idx = IW'(i);
      end
      if (r_vld[i] && (r_tag[i] == UPD_ADR_SD)) begin
        w_up_hit = 1'b1;
        w_up_idx = IW'(i);
      end
    end
  end

  // Prediction: returns with a non-empty stack follow the stack top, otherwise the counter decides.
  always_comb begin
    PRED_TAKEN_SP = 1'b0;
    PRED_ADR_SP   = '0;
    if (w_lk_hit) begin
      if (r_ret[w_lk_idx] && w_ras_nz) begin
        PRED_TAKEN_SP = 1'b1;
        PRED_ADR_SP   = w_ras_top;
      end else if (r_ctr[w_lk_idx][1]) begin
        PRED_TAKEN_SP = 1'b1;
        PRED_ADR_SP   = r_tgt[w_lk_idx];
      end
    end
  end

  // BTB update: train on hit, allocate round-robin on taken miss, ignore not-taken misses.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < ENTRIES; i++) begin
        r_vld[i] <= 1'b0;
        r_tag[i] <= '0;
        r_tgt[i] <= '0;
        r_ret[i] <= 1'b0;
        r_ctr[i] <= 2'd0;
      end
      r_ptr <= '0;
    end else if (UPD_VALID_SD) begin
      if (w_up_hit) begin
        if (UPD_TAKEN_SD) begin
          if (r_ctr[w_up_idx] != 2'd3) r_ctr[w_up_idx] <= r_ctr[w_up_idx] + 2'd1;
          r_tgt[w_up_idx] <= UPD_TARGET_SD;
          r_ret[w_up_idx] <= w_upd_ret;
        end else if (r_ctr[w_up_idx] != 2'd0) begin
          r_ctr[w_up_idx] <= r_ctr[w_up_idx] - 2'd1;
        end
      end else if (UPD_TAKEN_SD) begin
        r_vld[r_ptr] <= 1'b1;
        r_tag[r_ptr] <= UPD_ADR_SD;
        r_tgt[r_ptr] <= UPD_TARGET_SD;
        r_ret[r_ptr] <= w_upd_ret;
        r_ctr[r_ptr] <= 2'd2;
        r_ptr        <= r_ptr + IW'(1);
      end
    end
  end

`ifdef BPU_RAS_EN
  localparam int RW = $clog2(RAS_DEPTH);

  logic [ADR_W-1:0] r_ras [RAS_DEPTH];
  logic [RW-1:0]    r_ras_ptr;
  logic [RW:0]      r_ras_cnt;

  assign w_upd_ret    = UPD_IS_RET_SD;
  assign w_ras_nz     = (r_ras_cnt != '0);
  assign w_ras_top    = r_ras[r_ras_ptr - RW'(1)];
  assign RAS_EMPTY_SP = (r_ras_cnt == '0);

  // Circular return stack; push+pop on a non-empty stack replaces the top in place.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < RAS_DEPTH; i++) r_ras[i] <= '0;
      r_ras_ptr <= '0;
      r_ras_cnt <= '0;
    end else if (RAS_PUSH_SD && RAS_POP_SD && w_ras_nz) begin
      r_ras[r_ras_ptr - RW'(1)] <= RAS_ADR_SD;
    end else if (RAS_PUSH_SD) begin
      r_ras[r_ras_ptr] <= RAS_ADR_SD;
      r_ras_ptr        <= r_ras_ptr + RW'(1);
      if (r_ras_cnt != (RW+1)'(RAS_DEPTH)) r_ras_cnt <= r_ras_cnt + (RW+1)'(1);
    end else if (RAS_POP_SD && w_ras_nz) begin
      r_ras_ptr <= r_ras_ptr - RW'(1);
      r_ras_cnt <= r_ras_cnt - (RW+1)'(1);
    end
  end
`else
  logic w_unused_ras;

  assign w_unused_ras = &{1'b0, UPD_IS_RET_SD, RAS_PUSH_SD, RAS_POP_SD, RAS_ADR_SD};
  assign w_upd_ret    = 1'b0;
  assign w_ras_nz     = 1'b0;
  assign w_ras_top    = '0;
  assign RAS_EMPTY_SP = 1'b1;
`endif

endmodule

// File: tb/tb_branch_pred_unit.sv
module tb_branch_pred_unit;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] LOOKUP_ADR_SI = '0;
  logic        PRED_TAKEN_SP;
  logic [31:0] PRED_ADR_SP;
  logic        UPD_VALID_SD = 1'b0;
  logic [31:0] UPD_ADR_SD = '0;
  logic [31:0] UPD_TARGET_SD = '0;
  logic        UPD_TAKEN_SD = 1'b0;
  logic        UPD_IS_RET_SD = 1'b0;
  logic        RAS_PUSH_SD = 1'b0;
  logic        RAS_POP_SD = 1'b0;
  logic [31:0] RAS_ADR_SD = '0;
  logic        RAS_EMPTY_SP;

  int n_tests = 0;
  int n_fail  = 0;

  branch_pred_unit #(.ENTRIES(4), .ADR_W(32), .RAS_DEPTH(8)) dut (
    .clk(clk), .reset(reset),
    .LOOKUP_ADR_SI(LOOKUP_ADR_SI), .PRED_TAKEN_SP(PRED_TAKEN_SP), .PRED_ADR_SP(PRED_ADR_SP),
    .UPD_VALID_SD(UPD_VALID_SD), .UPD_ADR_SD(UPD_ADR_SD), .UPD_TARGET_SD(UPD_TARGET_SD),
    .UPD_TAKEN_SD(UPD_TAKEN_SD), .UPD_IS_RET_SD(UPD_IS_RET_SD),
    .RAS_PUSH_SD(RAS_PUSH_SD), .RAS_POP_SD(RAS_POP_SD), .RAS_ADR_SD(RAS_ADR_SD),
    .RAS_EMPTY_SP(RAS_EMPTY_SP)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic upd(input logic [31:0] adr, input logic [31:0] tgt, input logic tk, input logic rt);
    UPD_VALID_SD  = 1'b1;
    UPD_ADR_SD    = adr;
    UPD_TARGET_SD = tgt;
    UPD_TAKEN_SD  = tk;
    UPD_IS_RET_SD = rt;
    tick();
    UPD_VALID_SD  = 1'b0;
    UPD_TAKEN_SD  = 1'b0;
    UPD_IS_RET_SD = 1'b0;
  endtask

  task automatic ras(input logic psh, input logic pop, input logic [31:0] adr);
    RAS_PUSH_SD = psh;
    RAS_POP_SD  = pop;
    RAS_ADR_SD  = adr;
    tick();
    RAS_PUSH_SD = 1'b0;
    RAS_POP_SD  = 1'b0;
  endtask

  task automatic look(input string tag, input logic [31:0] adr, input logic tk, input logic [31:0] tgt);
    LOOKUP_ADR_SI = adr;
    #1;
    chk({tag, "_tk"}, {31'd0, PRED_TAKEN_SP}, {31'd0, tk});
    chk({tag, "_adr"}, PRED_ADR_SP, tgt);
  endtask

  initial begin
    do_reset();
    look("rst", 32'h100, 1'b0, 32'h0);
    chk("rst_empty", {31'd0, RAS_EMPTY_SP}, 32'd1);

    // Counter training on 0x100.
    upd(32'h100, 32'h200, 1'b1, 1'b0);
    look("alloc", 32'h100, 1'b1, 32'h200);
    upd(32'h100, 32'h999, 1'b0, 1'b0);
    look("wnt", 32'h100, 1'b0, 32'h0);
    upd(32'h100, 32'h999, 1'b0, 1'b0);
    look("snt", 32'h100, 1'b0, 32'h0);
    upd(32'h100, 32'h999, 1'b0, 1'b0);
    upd(32'h100, 32'h200, 1'b1, 1'b0);
    look("sat0", 32'h100, 1'b0, 32'h0);
    upd(32'h100, 32'h200, 1'b1, 1'b0);
    look("retrain", 32'h100, 1'b1, 32'h200);

    // Reset wins over a same-cycle update.
    reset = 1'b1;
    upd(32'h700, 32'h7000, 1'b1, 1'b0);
    reset = 1'b0;
    look("rst_wins", 32'h700, 1'b0, 32'h0);
    look("rst_clr", 32'h100, 1'b0, 32'h0);

    // Round-robin replacement, not-taken misses never allocate.
    for (int i = 1; i <= 5; i++) upd(32'h10 * i, 32'h1000 + 32'h10 * i, 1'b1, 1'b0);
    look("evict10", 32'h10, 1'b0, 32'h0);
    look("hit20", 32'h20, 1'b1, 32'h1020);
    look("hit30", 32'h30, 1'b1, 32'h1030);
    look("hit40", 32'h40, 1'b1, 32'h1040);
    look("hit50", 32'h50, 1'b1, 32'h1050);
    upd(32'h60, 32'h1060, 1'b0, 1'b0);
    look("nt_noalloc", 32'h60, 1'b0, 32'h0);
    upd(32'h70, 32'h1070, 1'b1, 1'b0);
    look("ptr_evict20", 32'h20, 1'b0, 32'h0);
    look("ptr_keep30", 32'h30, 1'b1, 32'h1030);
    look("hit70", 32'h70, 1'b1, 32'h1070);

    // Same-cycle update and lookup sees old contents.
    upd(32'h100, 32'h200, 1'b1, 1'b0);
    UPD_VALID_SD  = 1'b1;
    UPD_ADR_SD    = 32'h100;
    UPD_TARGET_SD = 32'h300;
    UPD_TAKEN_SD  = 1'b1;
    look("nobypass", 32'h100, 1'b1, 32'h200);
    tick();
    UPD_VALID_SD  = 1'b0;
    UPD_TAKEN_SD  = 1'b0;
    look("after_upd", 32'h100, 1'b1, 32'h300);

`ifdef BPU_RAS_EN
    do_reset();
    ras(1'b1, 1'b0, 32'hA0);
    ras(1'b1, 1'b0, 32'hB0);
    upd(32'h400, 32'h4444, 1'b1, 1'b1);
    look("ras_b0", 32'h400, 1'b1, 32'hB0);
    chk("ras_nempty", {31'd0, RAS_EMPTY_SP}, 32'd0);
    ras(1'b0, 1'b1, 32'h0);
    look("ras_a0", 32'h400, 1'b1, 32'hA0);
    ras(1'b0, 1'b1, 32'h0);
    chk("ras_empty1", {31'd0, RAS_EMPTY_SP}, 32'd1);
    ras(1'b0, 1'b1, 32'h0);
    chk("ras_empty2", {31'd0, RAS_EMPTY_SP}, 32'd1);
    look("ras_fallback", 32'h400, 1'b1, 32'h4444);

    // Overflow: nine pushes keep the latest eight.
    for (int i = 1; i <= 9; i++) ras(1'b1, 1'b0, i);
    for (int i = 9; i >= 2; i--) begin
      look("ras_top", 32'h400, 1'b1, i);
      ras(1'b0, 1'b1, 32'h0);
    end
    chk("ras_ovf_empty", {31'd0, RAS_EMPTY_SP}, 32'd1);

    // Push+pop replaces the top; count stays at three.
    for (int i = 1; i <= 3; i++) ras(1'b1, 1'b0, i);
    ras(1'b1, 1'b1, 32'hF0);
    look("pp_top", 32'h400, 1'b1, 32'hF0);
    ras(1'b0, 1'b1, 32'h0);
    look("pp_2", 32'h400, 1'b1, 32'h2);
    ras(1'b0, 1'b1, 32'h0);
    look("pp_1", 32'h400, 1'b1, 32'h1);
    ras(1'b0, 1'b1, 32'h0);
    chk("pp_empty", {31'd0, RAS_EMPTY_SP}, 32'd1);
`else
    // Stack compiled out: pushes and is_ret are ignored.
    ras(1'b1, 1'b0, 32'hA0);
    chk("noras_empty", {31'd0, RAS_EMPTY_SP}, 32'd1);
    upd(32'h400, 32'h4444, 1'b1, 1'b1);
    look("noras_ret", 32'h400, 1'b1, 32'h4444);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/branch_pred_unit.md
# branch_pred_unit

Parametrised branch predictor for the fetch stage. It pairs a fully associative branch target buffer, holding a 2-bit saturating counter per entry, with an optional return-address stack. The fetch stage drives the current fetch address and gets a combinational taken/target prediction in the same cycle. The execute stage writes back resolved branches and call/return events, and these update the tables on the next clock edge.

## Interface
- ENTRIES, 4: BTB entry count; power of two, ≥2
- ADR_W, 32: address width
- RAS_DEPTH, 8: return-stack depth; power of two, ≥2 (used only with BPU_RAS_EN)

Ports:
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  synchronous, active-high reset
- LOOKUP_ADR_SI  in  ADR_W  fetch address to predict
- PRED_TAKEN_SP  out  1  prediction: taken
- PRED_ADR_SP  out  ADR_W  predicted target; 0 when PRED_TAKEN_SP=0
- UPD_VALID_SD  in  1  resolved-branch update strobe
- UPD_ADR_SD  in  ADR_W  address of resolved branch
- UPD_TARGET_SD  in  ADR_W  resolved target
- UPD_TAKEN_SD  in  1  resolved outcome
- UPD_IS_RET_SD  in  1  resolved instruction is a return
- RAS_PUSH_SD  in  1  call retired: push RAS_ADR_SD
- RAS_POP_SD  in  1  return retired: pop
- RAS_ADR_SD  in  ADR_W  return address to push
- RAS_EMPTY_SP  out  1  stack holds no valid entry

## Operation
- Each BTB entry holds valid, tag (full ADR_W address), target, is_ret and a counter (0 SNT, 1 WNT, 2 WT, 3 ST).
- Lookup is combinational.
  - The hit is the lowest index with valid && tag==LOOKUP_ADR_SI.
  - A hit predicts taken when counter[1]=1, with PRED_ADR_SP = target.
  - A miss gives PRED_TAKEN_SP=0 and PRED_ADR_SP=0.
- Update, applied at the edge where UPD_VALID_SD=1:
  - **Hit** (lowest matching index): the counter saturates up on UPD_TAKEN_SD=1 and down otherwise. On taken, target is overwritten with UPD_TARGET_SD and is_ret with UPD_IS_RET_SD.
  - **Miss and taken**: allocate at the round-robin pointer with valid=1, tag, target, is_ret and counter=2. The pointer then increments modulo ENTRIES, overwriting the oldest entry once the table is full.
  - **Miss and not taken**: no state change; not-taken branches are never allocated.
- Because updates hit before they allocate, the table never holds duplicate tags.
- Reset clears every valid, tag, target, counter and is_ret bit, and sets the pointer to 0.
- Reset values of outputs: PRED_TAKEN_SP=0, PRED_ADR_SP=0, RAS_EMPTY_SP=1.
- Reset wins over a same-cycle update or push/pop.

## Timing
- Lookup to prediction: 0 cycles (combinational).
- An update is visible to lookup in the cycle after its edge. A lookup in the same cycle as an update to the same address sees the old contents; there is no bypass.
- Pushes and pops take effect at the edge. The new top of stack is visible the next cycle.
- No backpressure; every strobe is accepted every cycle.

## Configuration
Macro: BPU_RAS_EN.

Defined (RAS compiled in):
- Storage is a circular stack of RAS_DEPTH entries with a top pointer and a count from 0 to RAS_DEPTH.
- **Push**: write the entry at the pointer, increment the pointer modulo RAS_DEPTH, and set count=min(count+1, RAS_DEPTH). Overflow silently overwrites the oldest entry.
- **Pop**: decrement the pointer and count. A pop with count=0 is ignored.
- **Push and pop in the same cycle**: the top entry is overwritten with RAS_ADR_SD and count is unchanged. If count=0, this acts as a plain push.
- **Lookup hit on an entry with is_ret=1 and count>0**: PRED_TAKEN_SP=1 and PRED_ADR_SP=top of stack, ignoring the counter.
- **Lookup hit on an entry with is_ret=1 and count=0**: the normal counter/target prediction applies.
- RAS_EMPTY_SP = (count==0).

Undefined (RAS compiled out):
- No stack storage is built.
- RAS_PUSH_SD, RAS_POP_SD, RAS_ADR_SD and UPD_IS_RET_SD are ignored, and is_ret is never set.
- RAS_EMPTY_SP is tied to 1.
- Port list is identical in both builds.

## Test plan
- Reset, then lookup 0x100 → PRED_TAKEN_SP=0, PRED_ADR_SP=0, RAS_EMPTY_SP=1.
- Update 0x100 taken to 0x200, then lookup 0x100 next cycle → taken, target 0x200. Two not-taken updates on 0x100 → not taken (counter 2→1→0). A third not-taken update keeps counter 0. Two taken updates → taken again.
- ENTRIES=4: taken updates for 0x10, 0x20, 0x30, 0x40, 0x50 → 0x10 is evicted and misses; 0x20–0x50 hit. A not-taken update to unseen 0x60 → no allocation, and the pointer is unchanged.
- Same-cycle update (0x100 taken to 0x300) and lookup of 0x100 → the old prediction is seen. The next cycle gives 0x300.
- BPU_RAS_EN defined:
  - Push 0xA0, push 0xB0, then allocate 0x400 with is_ret=1 → lookup 0x400 gives 0xB0.
  - Pop → lookup 0x400 gives 0xA0.
  - Pop, then pop again → the extra pop is ignored, RAS_EMPTY_SP=1, and lookup 0x400 falls back to the stored target.
- BPU_RAS_EN defined, RAS_DEPTH=8:
  - 9 pushes of 0x1..0x9 → count=8.
  - 8 pops → tops seen in order 0x9..0x2, then RAS_EMPTY_SP=1.
  - Simultaneous push 0xF0 and pop with count 3 → top=0xF0 and count stays 3.
